// File: rtl/emitter_sched_rr.sv
`default_nettype none
// ============================================================================
//  Module   : emitter_sched_rr
//  Purpose  : Combinational rotating-priority picker. Returns the first
//             asserted request found when searching from i_ptr+1 upward,
//             modulo N.
//  Ports    : i_req  [N]   request vector
//             i_ptr  [PW]  index of the most recently served requester
//             o_gnt  [N]   one-hot grant, zero when no request is pending
//             o_idx  [PW]  binary index of the granted requester
//             o_any        at least one request is pending
//  Revision : 1.0  initial release
// ============================================================================
module emitter_sched_rr #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    localparam logic [PW+1:0] c_n = (PW+2)'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [PW:0]    w_start;
    logic [PW:0]    w_off;
    logic           w_hit;
    logic [PW+1:0]  w_sum;

    // Two copies of the request vector side by side: shifting right by
    // ptr+1 leaves a window whose bit j is request (ptr+1+j) mod N, so the
    // lowest set bit of the window is the round-robin winner. ptr = N-1
    // selects the upper copy unchanged, i.e. the search starts at index 0.
    assign w_dbl   = {i_req, i_req};
    assign w_start = {1'b0, i_ptr} + (PW+1)'(1);
    assign w_rot   = N'(w_dbl >> w_start);

    // Descending scan: the last hit written is the lowest window position.
    always_comb begin
        w_off = '0;
        w_hit = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (PW+1)'(j);
                w_hit = 1'b1;
            end
        end
    end

    // Map the window position back to a source index.
    assign w_sum = {1'b0, w_start} + {1'b0, w_off};
    assign o_idx = (w_sum >= c_n) ? PW'(w_sum - c_n) : PW'(w_sum);
    assign o_gnt = w_hit ? (N'(1) << o_idx) : '0;
    assign o_any = w_hit;

endmodule
`default_nettype wire

// File: rtl/emitter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : emitter_sched
//  Purpose  : Packet-atomic round-robin scheduler sharing one emitter's
//             AXI-stream byte input between N producers. A granted source
//             keeps ownership until its tlast beat is accepted; one output
//             register stage sits between the sources and the emitter.
//  Ports    : i_clk, i_rst        clock, asynchronous active-high reset
//             i_tdata/i_tlast/i_tvalid, o_tready   N source streams
//             o_tdata/o_tlast/o_tvalid, i_tready   stream to the emitter
//             o_grant [N]         one-hot current owner, zero when idle
//             o_busy              a packet is locked
//  Revision : 1.0  initial release
// ============================================================================
module emitter_sched #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N*W-1:0] i_tdata,
    input  logic [N-1:0]   i_tlast,
    input  logic [N-1:0]   i_tvalid,
    output logic [N-1:0]   o_tready,
    output logic [W-1:0]   o_tdata,
    output logic           o_tlast,
    output logic           o_tvalid,
    input  logic           i_tready,
    output logic [N-1:0]   o_grant,
    output logic           o_busy
);

    localparam int PW = $clog2(N);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_lock = 1'b1;

    logic [0:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_gidx;
    logic [N-1:0]  r_grant;
    logic          r_busy;
    logic [W-1:0]  r_tdata;
    logic          r_tlast;
    logic          r_tvalid;

    logic [0:0]    w_state_nx;
    logic [PW-1:0] w_ptr_nx;
    logic [PW-1:0] w_gidx_nx;
    logic [N-1:0]  w_grant_nx;
    logic          w_busy_nx;
    logic [W-1:0]  w_tdata_nx;
    logic          w_tlast_nx;
    logic          w_tvalid_nx;

    logic [N-1:0]  w_rr_gnt;
    logic [PW-1:0] w_rr_idx;
    logic          w_rr_any;

    logic          w_sel_valid;
    logic          w_sel_last;
    logic [W-1:0]  w_sel_data;
    logic          w_out_ready;
    logic          w_accept;

    emitter_sched_rr #(
        .N  (N),
        .PW (PW)
    ) u_rr (
        .i_req (i_tvalid),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // Stream of the current owner; only meaningful while locked.
    assign w_sel_valid = i_tvalid[r_gidx];
    assign w_sel_last  = i_tlast[r_gidx];
    assign w_sel_data  = i_tdata[r_gidx*W +: W];

    // Ready depends only on the output register and the emitter, never on
    // a source's tvalid. r_grant is zero in IDLE, so every ready is low
    // there and no beat can slip through during arbitration.
    assign w_out_ready = ~r_tvalid | i_tready;
    assign o_tready    = r_grant & {N{w_out_ready}};
    assign w_accept    = (r_state == c_lock) & w_sel_valid & w_out_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_ptr;
        w_gidx_nx   = r_gidx;
        w_grant_nx  = r_grant;
        w_busy_nx   = r_busy;
        w_tdata_nx  = r_tdata;
        w_tlast_nx  = r_tlast;
        w_tvalid_nx = r_tvalid;

        // The emitter may drain the output register in either state; the
        // final beat of a packet is often still held here during IDLE.
        if (r_tvalid && i_tready) begin
            w_tvalid_nx = 1'b0;
        end

        case (r_state)
            c_idle: begin
                if (w_rr_any) begin
                    w_state_nx = c_lock;
                    w_grant_nx = w_rr_gnt;
                    w_gidx_nx  = w_rr_idx;
                    w_busy_nx  = 1'b1;
                end
            end
            c_lock: begin
                if (w_accept) begin
                    w_tdata_nx  = w_sel_data;
                    w_tlast_nx  = w_sel_last;
                    w_tvalid_nx = 1'b1;
                    if (w_sel_last) begin
                        w_state_nx = c_idle;
                        w_ptr_nx   = r_gidx;
                        w_grant_nx = '0;
                        w_busy_nx  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx = c_idle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= c_idle;
            r_ptr    <= PW'(N - 1);
            r_gidx   <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_gidx   <= w_gidx_nx;
            r_grant  <= w_grant_nx;
            r_busy   <= w_busy_nx;
            r_tdata  <= w_tdata_nx;
            r_tlast  <= w_tlast_nx;
            r_tvalid <= w_tvalid_nx;
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;
    assign o_tvalid = r_tvalid;
    assign o_grant  = r_grant;
    assign o_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_emitter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_emitter_sched
//  Purpose  : Self-checking bench for emitter_sched. Source queues feed the
//             DUT; a transaction-level model (owner, pointer, in-flight
//             beat queue) predicts grant, ready and output on every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_emitter_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] s_tdata = '0;
    logic [N-1:0]   s_tlast = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tready;
    logic [W-1:0]   m_tdata;
    logic           m_tlast;
    logic           m_tvalid;
    logic           m_tready = 1'b1;
    logic [N-1:0]   grant;
    logic           busy;

    emitter_sched #(.N(N), .W(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_tdata  (s_tdata),
        .i_tlast  (s_tlast),
        .i_tvalid (s_tvalid),
        .o_tready (s_tready),
        .o_tdata  (m_tdata),
        .o_tlast  (m_tlast),
        .o_tvalid (m_tvalid),
        .i_tready (m_tready),
        .o_grant  (grant),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- source side ----------------
    logic [W:0]   src_q[N][$];
    int           src_hold[N];
    logic [N-1:0] hs;

    initial begin
        for (int k = 0; k < N; k++) src_hold[k] = 0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_hold[k] > 0) begin
                    src_hold[k]--;
                    s_tvalid[k] = 1'b0;
                end else if (src_q[k].size() > 0) begin
                    s_tvalid[k]          = 1'b1;
                    s_tdata[k*W +: W]    = src_q[k][0][W-1:0];
                    s_tlast[k]           = src_q[k][0][W];
                end else begin
                    s_tvalid[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [W:0] mq[$];       // beat held in the output register (0 or 1)
    logic [W:0] log_q[$];    // beats delivered to the emitter
    int         log_cyc[$];
    int         m_owner = -1;
    int         m_ptr   = N - 1;

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int s = 1; s <= N; s++) begin
            int c;
            c = (p + s) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : p_cmp
        logic ev;
        logic er;
        if (rst) begin
            chk("rst o_tvalid", {31'd0, m_tvalid}, 32'd0);
            chk("rst o_grant", {28'd0, grant}, 32'd0);
            chk("rst o_busy", {31'd0, busy}, 32'd0);
            chk("rst o_tready", {28'd0, s_tready}, 32'd0);
            mq.delete();
            m_owner = -1;
            m_ptr   = N - 1;
        end else begin
            ev = (mq.size() != 0);
            chk("o_tvalid", {31'd0, m_tvalid}, {31'd0, ev});
            if (ev) begin
                chk("o_tdata", {24'd0, m_tdata}, {24'd0, mq[0][W-1:0]});
                chk("o_tlast", {31'd0, m_tlast}, {31'd0, mq[0][W]});
            end
            er = (m_owner >= 0) && (!ev || m_tready);
            chk("o_grant", {28'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("o_busy", {31'd0, busy}, (m_owner >= 0) ? 32'd1 : 32'd0);
            chk("o_tready", {28'd0, s_tready}, er ? (32'd1 << m_owner) : 32'd0);
            if (ev && m_tready) begin
                log_q.push_back(mq.pop_front());
                log_cyc.push_back(cyc);
            end
            if (m_owner >= 0) begin
                if (er && s_tvalid[m_owner]) begin
                    mq.push_back({s_tlast[m_owner], s_tdata[m_owner*W +: W]});
                    if (s_tlast[m_owner]) begin
                        m_ptr   = m_owner;
                        m_owner = -1;
                    end
                end
            end else if (|s_tvalid) begin
                m_owner = rr_pick(m_ptr, s_tvalid);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int k, input int len, input logic [W-1:0] base);
        for (int i = 0; i < len; i++) src_q[k].push_back({(i == len - 1), W'(base + W'(i))});
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, (log_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [W:0] exp);
        if (idx < log_q.size()) chk(name, {23'd0, log_q[idx]}, {23'd0, exp});
        else chk(name, 32'hFFFF_FFFF, {23'd0, exp});
    endtask

    task automatic start_test();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            src_hold[k] = 0;
        end
        m_tready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
        log_cyc.delete();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int pushed;
        int len;

        // Single packet from source 0
        start_test();
        push_pkt(0, 3, 8'h41);
        tick();
        chk("single grant before arb", {28'd0, grant}, 32'h0);
        tick();
        chk("single grant after arb", {28'd0, grant}, 32'h1);
        wait_log(3, 50, "single timeout");
        chk_log("single beat0", 0, 9'h041);
        chk_log("single beat1", 1, 9'h042);
        chk_log("single beat2", 2, 9'h143);
        if (log_cyc.size() >= 3) begin
            chk("single back-to-back 1", log_cyc[1] - log_cyc[0], 32'd1);
            chk("single back-to-back 2", log_cyc[2] - log_cyc[1], 32'd1);
        end
        chk("single busy after last", {31'd0, busy}, 32'd0);

        // Contention between sources 0 and 2, then pointer favours source 0
        start_test();
        push_pkt(0, 2, 8'h10);
        push_pkt(2, 2, 8'h20);
        wait_log(4, 60, "contention timeout");
        chk_log("contention 0", 0, 9'h010);
        chk_log("contention 1", 1, 9'h111);
        chk_log("contention 2", 2, 9'h020);
        chk_log("contention 3", 3, 9'h121);
        push_pkt(0, 1, 8'h31);
        push_pkt(2, 1, 8'h32);
        wait_log(6, 60, "contention2 timeout");
        chk_log("contention src0 first", 4, 9'h131);
        chk_log("contention src2 second", 5, 9'h132);

        // Fairness: all four sources with single-beat packets
        start_test();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push_pkt(k, 1, W'(k));
        wait_log(8, 120, "fairness timeout");
        for (int i = 0; i < 8; i++) chk_log("fairness order", i, {1'b1, W'(i % N)});

        // Backpressure mid-packet
        start_test();
        push_pkt(0, 4, 8'h50);
        wait_log(1, 50, "backpressure timeout");
        m_tready = 1'b0;
        repeat (5) begin
            #1;
            chk("bp o_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("bp o_tdata", {24'd0, m_tdata}, 32'h51);
            chk("bp o_tready", {28'd0, s_tready}, 32'd0);
            tick();
        end
        m_tready = 1'b1;
        wait_log(4, 50, "backpressure drain timeout");
        chk("bp beat count", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("bp beat", i, {(i == 3), W'(8'h50 + i)});

        // Lock hold while the owner stalls and another source waits
        start_test();
        push_pkt(1, 4, 8'h60);
        wait_log(1, 50, "lock timeout");
        src_hold[1] = 3;
        push_pkt(2, 1, 8'h70);
        repeat (5) begin
            chk("lock grant held", {28'd0, grant}, 32'h2);
            tick();
        end
        wait_log(5, 60, "lock drain timeout");
        chk_log("lock 0", 0, 9'h060);
        chk_log("lock 1", 1, 9'h061);
        chk_log("lock 2", 2, 9'h062);
        chk_log("lock 3", 3, 9'h163);
        chk_log("lock src2 after", 4, 9'h170);

        // Asynchronous reset in the middle of a packet
        start_test();
        push_pkt(0, 4, 8'h80);
        wait_log(1, 50, "reset-test timeout");
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async rst o_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("async rst o_tready", {28'd0, s_tready}, 32'd0);
        chk("async rst o_grant", {28'd0, grant}, 32'd0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
        log_cyc.delete();
        push_pkt(0, 1, 8'h90);
        push_pkt(3, 1, 8'h93);
        wait_log(2, 50, "post-reset timeout");
        chk_log("post-reset src0 first", 0, 9'h190);
        chk_log("post-reset src3 second", 1, 9'h193);
        chk("post-reset beat count", log_q.size(), 32'd2);

        // Randomized traffic, stalls and backpressure
        start_test();
        pushed = 0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 4);
                    push_pkt(k, len, W'($urandom));
                    pushed += len;
                end
                if (src_hold[k] == 0 && $urandom_range(0, 15) == 0)
                    src_hold[k] = $urandom_range(1, 3);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        m_tready = 1'b1;
        wait_log(pushed, 400, "random drain timeout");
        chk("random beat count", log_q.size(), pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
